forward_write_arbiter: RTL and testbench
========================================

// Module: forward_write_arbiter
// PURPOSE
//  Per-slave write-path arbiter for the crossbar; one instance per slave port.
//  - Picks one master among those with an AW request decoded to this slave (round-robin).
//  - Locks the grant from AW acceptance through the WLAST beat of that burst.
//  - Records each accepted burst's master number in an in-order queue for B-channel return routing.
// PARAMETERS
//  masters            2  number of master ports (>=2); index width MW = $clog2(masters)
//  i_am_slave_number  0  slave port this instance serves (informational, debug tag)
//  bq_depth           4  entries in B-return order queue (power of 2, >=2)
// PORTS
//  ACLK                 in   1           clock; all logic on posedge
//  ARESET               in   1           synchronous reset, active-high
//  master_aw_req        in   masters     bit i = master i AWVALID with address decoded to this slave
//  aw_handshake         in   1           AWVALID&AWREADY at slave side for granted master
//  w_handshake          in   1           WVALID&WREADY at slave side for granted master
//  w_last               in   1           WLAST of the current W beat
//  b_handshake          in   1           BVALID&BREADY on this slave's B channel
//  aw_grant_valid       out  1           AW mux enabled for grant_master_number
//  w_grant_valid        out  1           W mux enabled for grant_master_number
//  grant_master_number  out  MW          master currently owning this slave's write path
//  bq_master_dest       out  MW          head of B-return queue: master owed the next B response
//  bq_empty             out  1           B-return queue empty
//  bq_full              out  1           B-return queue full
// BEHAVIOUR
//  Reset (ARESET=1 at posedge, also mid-burst): state=IDLE.
//   - rr_ptr=0; queue flushed.
//   - Outputs: aw_grant_valid=0, w_grant_valid=0, grant_master_number=0,
//     bq_master_dest=0, bq_empty=1, bq_full=0.
//   - In-flight bursts are abandoned; no completion is required.
//  FSM (registered state; all grant outputs are registered):
//   IDLE: if |master_aw_req && !bq_full:
//     - Winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod masters.
//     - Next cycle: grant_master_number=winner, aw_grant_valid=1, state=ADDR.
//     - Latency is exactly 1 cycle from request sampled to grant visible.
//     - If bq_full, stay in IDLE and grant nothing.
//   ADDR: hold grant; requests from other masters are ignored.
//     - On aw_handshake: push grant_master_number into queue.
//     - Next cycle: aw_grant_valid=0, w_grant_valid=1, state=DATA.
//     - A granted master deasserting its request is illegal AXI; grant is held regardless.
//   DATA: each w_handshake is one beat, with no beat counting.
//     - On w_handshake&&w_last: next cycle w_grant_valid=0, state=IDLE,
//       rr_ptr = (grant_master_number+1) mod masters.
//     - grant_master_number holds its value until the next grant.
//   W is never granted before its AW is accepted; W-before-AW from a master stalls at the mux.
//   aw_handshake outside ADDR and w_handshake outside DATA are ignored.
//   Back-to-back bursts: the earliest next-grant cycle is the cycle after return to IDLE,
//   i.e. 2 cycles between a WLAST beat and the next aw_grant_valid.
//   Round-robin wrap: rr_ptr = masters-1 wraps its successor to 0. rr_ptr is never advanced in IDLE/ADDR.
//  B-return queue: circular buffer of MW-bit entries, bq_depth deep.
//   - Push on ADDR&&aw_handshake; pop on b_handshake && !bq_empty.
//   - b_handshake with bq_empty=1 is ignored; no pointer change.
//   - Simultaneous push and pop when full: both occur, count unchanged.
//   - Simultaneous push and pop when empty: push only (pop ignored).
//   - bq_master_dest = head entry, or 0 when empty; bq_full/bq_empty come from the registered count.
//   - Pointers wrap mod bq_depth.
// TESTING
//  1. Reset: all outputs at reset values; master_aw_req=2'b11, ARESET=1 -> no grant while reset held.
//  2. Round-robin: masters=2, both request after reset -> first grant 0.
//     After 1-beat burst (WLAST), both request -> grant 1, then grant 0.
//  3. Burst lock: grant master 0, 4-beat burst, master 1 requests throughout ->
//     - grant_master_number stays 0 and w_grant_valid=1 until 4th beat;
//     - aw_grant_valid for master 1 rises 2 cycles after the WLAST beat.
//  4. Queue full: bq_depth=4, complete 4 bursts with no b_handshake ->
//     - bq_full=1 and the 5th request is not granted;
//     - one b_handshake -> bq_master_dest pops in push order, and the grant follows 1 cycle after bq_full falls.
//  5. Queue edges: b_handshake on empty queue -> no change.
//     Push+pop same cycle when full -> bq_full stays 1, head advances.
//  6. Reset mid-burst: ARESET in DATA after 2 of 4 beats -> next cycle IDLE, queue empty, rr_ptr=0, grants 0.

Source files
------------

// File: rtl/forward_write_arbiter.sv
// Per-slave write-path arbiter: round-robin AW grant locked through WLAST,
// plus an in-order queue of granted master numbers for B-response routing.
module forward_write_arbiter #(
    parameter int masters           = 2,
    parameter int i_am_slave_number = 0,
    parameter int bq_depth          = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [masters-1:0]         master_aw_req,
    input  logic                       aw_handshake,
    input  logic                       w_handshake,
    input  logic                       w_last,
    input  logic                       b_handshake,
    output logic                       aw_grant_valid,
    output logic                       w_grant_valid,
    output logic [$clog2(masters)-1:0] grant_master_number,
    output logic [$clog2(masters)-1:0] bq_master_dest,
    output logic                       bq_empty,
    output logic                       bq_full
);

    localparam int MW = $clog2(masters);
    localparam int PW = $clog2(bq_depth);
    localparam int CW = $clog2(bq_depth + 1);

    // Slave number is only a tag for identifying this instance in the hierarchy.
    localparam int unused_slave_tag = i_am_slave_number;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] grant_q, grant_d;
    logic [MW-1:0] rr_ptr_q, rr_ptr_d;
    logic [MW-1:0] winner;
    logic          found;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [MW-1:0] bq_mem_q [bq_depth];
    logic          push, pop, push_en;

    logic [2*masters-1:0] req_dbl;
    logic [masters-1:0]   req_rot;
    logic [MW:0]          sum;

    // Rotate requests so bit 0 is the master at rr_ptr, then take the first set bit.
    always_comb begin
        req_dbl = {master_aw_req, master_aw_req};
        req_rot = masters'(req_dbl >> rr_ptr_q);
        winner  = '0;
        found   = 1'b0;
        sum     = '0;
        for (int k = 0; k < masters; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (MW+1)'(k);
                if (sum >= (MW+1)'(masters)) begin
                    sum = sum - (MW+1)'(masters);
                end
                winner = sum[MW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found && !bq_full) begin
                    state_d = ADDR;
                    grant_d = winner;
                end
            end
            ADDR: begin
                if (aw_handshake) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_handshake && w_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == MW'(masters - 1)) ? '0 : grant_q + MW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entering ADDR requires a free slot, so the push never overflows in practice;
    // the guard keeps the queue consistent regardless.
    always_comb begin
        push     = (state_q == ADDR) && aw_handshake;
        pop      = b_handshake && !bq_empty;
        push_en  = push && (!bq_full || pop);
        wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_en) begin
            bq_mem_q[wr_ptr_q] <= grant_q;
        end
    end

    assign aw_grant_valid      = (state_q == ADDR);
    assign w_grant_valid       = (state_q == DATA);
    assign grant_master_number = grant_q;
    assign bq_empty            = (count_q == '0);
    assign bq_full             = (count_q == CW'(bq_depth));
    assign bq_master_dest      = bq_empty ? '0 : bq_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_forward_write_arbiter.sv
// Directed bench for forward_write_arbiter (2 masters, 4-deep B-return queue).
module tb_forward_write_arbiter;

    logic       ACLK;
    logic       ARESET;
    logic [1:0] master_aw_req;
    logic       aw_handshake;
    logic       w_handshake;
    logic       w_last;
    logic       b_handshake;
    logic       aw_grant_valid;
    logic       w_grant_valid;
    logic [0:0] grant_master_number;
    logic [0:0] bq_master_dest;
    logic       bq_empty;
    logic       bq_full;

    int errors = 0;
    int checks = 0;

    forward_write_arbiter #(
        .masters          (2),
        .i_am_slave_number(0),
        .bq_depth         (4)
    ) dut (
        .ACLK               (ACLK),
        .ARESET             (ARESET),
        .master_aw_req      (master_aw_req),
        .aw_handshake       (aw_handshake),
        .w_handshake        (w_handshake),
        .w_last             (w_last),
        .b_handshake        (b_handshake),
        .aw_grant_valid     (aw_grant_valid),
        .w_grant_valid      (w_grant_valid),
        .grant_master_number(grant_master_number),
        .bq_master_dest     (bq_master_dest),
        .bq_empty           (bq_empty),
        .bq_full            (bq_full)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awv"},   32'(aw_grant_valid), 0);
        check({tag, "_wv"},    32'(w_grant_valid), 0);
        check({tag, "_gmn"},   32'(grant_master_number), 0);
        check({tag, "_dest"},  32'(bq_master_dest), 0);
        check({tag, "_empty"}, 32'(bq_empty), 1);
        check({tag, "_full"},  32'(bq_full), 0);
    endtask

    initial begin
        ARESET = 1'b1; master_aw_req = 2'b11;
        aw_handshake = 0; w_handshake = 0; w_last = 0; b_handshake = 0;

        // Reset held with both masters requesting: nothing granted.
        tick(); tick(); tick();
        check_reset_outputs("rst");

        // Round-robin: first grant goes to master 0.
        ARESET = 1'b0;
        tick();
        check("rr0_awv", 32'(aw_grant_valid), 1);
        check("rr0_gmn", 32'(grant_master_number), 0);
        aw_handshake = 1; master_aw_req = 2'b10;
        tick();
        check("rr0_awv_off", 32'(aw_grant_valid), 0);
        check("rr0_wv", 32'(w_grant_valid), 1);
        check("rr0_dest", 32'(bq_master_dest), 0);
        check("rr0_empty", 32'(bq_empty), 0);
        aw_handshake = 0; w_handshake = 1; w_last = 1;
        tick();
        check("rr0_wv_off", 32'(w_grant_valid), 0);
        check("rr0_gmn_hold", 32'(grant_master_number), 0);
        w_handshake = 0; w_last = 0; master_aw_req = 2'b11;
        tick();
        check("rr1_awv", 32'(aw_grant_valid), 1);
        check("rr1_gmn", 32'(grant_master_number), 1);
        aw_handshake = 1;
        tick();
        aw_handshake = 0; w_handshake = 1; w_last = 1;
        tick();
        w_handshake = 0; w_last = 0;
        tick();
        check("rr2_gmn", 32'(grant_master_number), 0);
        check("rr2_awv", 32'(aw_grant_valid), 1);

        // Burst lock: 4-beat burst for master 0 while master 1 keeps requesting.
        aw_handshake = 1;
        tick();
        aw_handshake = 0; w_handshake = 1;
        for (int b = 0; b < 3; b++) begin
            tick();
            check("lock_gmn", 32'(grant_master_number), 0);
            check("lock_wv", 32'(w_grant_valid), 1);
        end
        w_last = 1;
        tick();
        check("lock_wv_off", 32'(w_grant_valid), 0);
        check("lock_awv_gap", 32'(aw_grant_valid), 0);
        w_handshake = 0; w_last = 0;
        tick();
        check("lock_next_awv", 32'(aw_grant_valid), 1);
        check("lock_next_gmn", 32'(grant_master_number), 1);

        // Fourth burst fills the queue (contents 0,1,0,1).
        aw_handshake = 1;
        tick();
        check("full_set", 32'(bq_full), 1);
        aw_handshake = 0; w_handshake = 1; w_last = 1;
        tick();
        w_handshake = 0; w_last = 0;
        tick();
        check("full_nogrant1", 32'(aw_grant_valid), 0);
        tick();
        check("full_nogrant2", 32'(aw_grant_valid), 0);
        check("full_head", 32'(bq_master_dest), 0);
        b_handshake = 1;
        tick();
        check("pop1_full", 32'(bq_full), 0);
        check("pop1_head", 32'(bq_master_dest), 1);
        check("pop1_awv", 32'(aw_grant_valid), 0);
        b_handshake = 0;
        tick();
        check("after_full_awv", 32'(aw_grant_valid), 1);
        check("after_full_gmn", 32'(grant_master_number), 0);

        // Push and pop in the same cycle: count holds, head advances (1 -> 0).
        aw_handshake = 1; b_handshake = 1;
        tick();
        check("pp_full", 32'(bq_full), 0);
        check("pp_empty", 32'(bq_empty), 0);
        check("pp_head", 32'(bq_master_dest), 0);
        aw_handshake = 0;

        // Drain remaining entries 0,1,0 then pop on an empty queue.
        tick();
        check("drain1_head", 32'(bq_master_dest), 1);
        tick();
        check("drain2_head", 32'(bq_master_dest), 0);
        tick();
        check("drain3_empty", 32'(bq_empty), 1);
        check("drain3_head", 32'(bq_master_dest), 0);
        tick();
        check("epop_empty", 32'(bq_empty), 1);
        check("epop_full", 32'(bq_full), 0);
        check("epop_head", 32'(bq_master_dest), 0);
        b_handshake = 0;

        // Finish master 0 burst, then grant master 1 and reset mid-burst.
        w_handshake = 1; w_last = 1;
        tick();
        w_handshake = 0; w_last = 0;
        tick();
        check("mid_gmn", 32'(grant_master_number), 1);
        aw_handshake = 1;
        tick();
        check("mid_push_head", 32'(bq_master_dest), 1);
        check("mid_push_empty", 32'(bq_empty), 0);
        aw_handshake = 0; w_handshake = 1;
        tick();
        tick();
        check("mid_wv", 32'(w_grant_valid), 1);
        ARESET = 1'b1;
        tick();
        check_reset_outputs("mrst");
        w_handshake = 0;
        tick();
        check("mrst_hold_awv", 32'(aw_grant_valid), 0);
        ARESET = 1'b0;
        tick();
        check("post_rst_awv", 32'(aw_grant_valid), 1);
        check("post_rst_gmn", 32'(grant_master_number), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
